// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter feeding one output stream, with optional multi-beat bursts per grant.
// A grant is locked once it is stalled or starts a burst, so the payload stays stable.
module fifo_rr_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned BURST_LEN  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           i__req_valid,
    input  logic [DATA_WIDTH-1:0]        ia__req_data [0:NUM_REQ-1],
    output logic [NUM_REQ-1:0]           o__req_ready,
    output logic                         o__data_out_valid,
    output logic [DATA_WIDTH-1:0]        o__data_out,
    input  logic                         i__data_out_ready,
    output logic [$clog2(NUM_REQ)-1:0]   o__grant_id,
    input  logic                         i__clear_all
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e         state_q, state_d;
    logic [IdW-1:0] g_q, g_d;
    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]     cnt_q, cnt_d;

    logic           sel_found;
    logic [IdW-1:0] sel_idx;
    int unsigned    cand;
    logic [IdW-1:0] grant;
    logic           has_grant;
    logic           xfer;

    function automatic logic [IdW-1:0] wrap_inc(input logic [IdW-1:0] x);
        return (x == IdW'(NUM_REQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // Cyclic first-valid search starting at rr_ptr.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            cand = 32'(rr_ptr_q) + j;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!sel_found && i__req_valid[IdW'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IdW'(cand);
            end
        end
    end

    assign grant     = (state_q == StBusy) ? g_q : sel_idx;
    assign has_grant = (state_q == StBusy) || sel_found;

    // Outputs are forced to zero only by reset; clear acts on state at the edge.
    always_comb begin
        o__data_out_valid = 1'b0;
        o__data_out       = '0;
        o__grant_id       = '0;
        o__req_ready      = '0;
        if (!reset && has_grant) begin
            o__data_out_valid   = i__req_valid[grant];
            o__data_out         = ia__req_data[grant];
            o__grant_id         = grant;
            o__req_ready[grant] = i__data_out_ready;
        end
    end

    assign xfer = o__data_out_valid && i__data_out_ready;

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    if (!xfer) begin
                        state_d = StBusy;
                        g_d     = sel_idx;
                        cnt_d   = 8'd0;
                    end else if (BURST_LEN == 1) begin
                        rr_ptr_d = wrap_inc(sel_idx);
                    end else begin
                        state_d = StBusy;
                        g_d     = sel_idx;
                        cnt_d   = 8'd1;
                    end
                end
            end
            StBusy: begin
                if (!i__req_valid[g_q]) begin
                    state_d  = StIdle;
                    rr_ptr_d = wrap_inc(g_q);
                    cnt_d    = 8'd0;
                end else if (xfer) begin
                    if ({1'b0, cnt_q} + 9'd1 == 9'(BURST_LEN)) begin
                        state_d  = StIdle;
                        rr_ptr_d = wrap_inc(g_q);
                        cnt_d    = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || i__clear_all) begin
            state_q  <= StIdle;
            g_q      <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: three instances (burst 1, 3, 4) share stimulus and are
// compared every cycle against a tenure-based reference model, plus directed scenarios.
module tb_fifo_rr_arbiter;

    localparam int DW = 16;
    localparam int NR = 4;

    logic          clk;
    logic          reset;
    logic          clr;
    logic [NR-1:0] valid;
    logic          ready;
    logic [DW-1:0] data [0:NR-1];

    logic [NR-1:0] rdy  [3];
    logic          ov   [3];
    logic [DW-1:0] dout [3];
    logic [1:0]    gid  [3];

    // Values sampled at the falling edge of the last step.
    logic [NR-1:0] s_rdy  [3];
    logic          s_ov   [3];
    logic [DW-1:0] s_dout [3];
    logic [1:0]    s_gid  [3];

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner = requester holding a locked tenure (-1 if none).
    int owner [3];
    int beats [3];
    int ptr   [3];
    int bl    [3];

    fifo_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(1)) u_dut1 (
        .clk(clk), .reset(reset), .i__req_valid(valid), .ia__req_data(data),
        .o__req_ready(rdy[0]), .o__data_out_valid(ov[0]), .o__data_out(dout[0]),
        .i__data_out_ready(ready), .o__grant_id(gid[0]), .i__clear_all(clr)
    );

    fifo_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(3)) u_dut3 (
        .clk(clk), .reset(reset), .i__req_valid(valid), .ia__req_data(data),
        .o__req_ready(rdy[1]), .o__data_out_valid(ov[1]), .o__data_out(dout[1]),
        .i__data_out_ready(ready), .o__grant_id(gid[1]), .i__clear_all(clr)
    );

    fifo_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(4)) u_dut4 (
        .clk(clk), .reset(reset), .i__req_valid(valid), .ia__req_data(data),
        .o__req_ready(rdy[2]), .o__data_out_valid(ov[2]), .o__data_out(dout[2]),
        .i__data_out_ready(ready), .o__grant_id(gid[2]), .i__clear_all(clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic vbit(input int k);
        logic [1:0] idx;
        idx = k[1:0];
        return valid[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            owner[i] = -1;
            beats[i] = 0;
            ptr[i]   = 0;
        end
    endtask

    task automatic model_check_update();
        int            grant;
        int            k;
        bit            has;
        bit            xfer;
        logic          e_ov;
        logic [DW-1:0] e_d;
        logic [NR-1:0] e_r;
        logic [1:0]    e_g;
        for (int i = 0; i < 3; i++) begin
            grant = 0;
            has   = 1'b0;
            if (owner[i] >= 0) begin
                grant = owner[i];
                has   = 1'b1;
            end else begin
                for (int j = 0; j < NR; j++) begin
                    k = (ptr[i] + j) % NR;
                    if (!has && vbit(k)) begin
                        grant = k;
                        has   = 1'b1;
                    end
                end
            end
            e_ov = 1'b0;
            e_d  = '0;
            e_r  = '0;
            e_g  = '0;
            if (!reset && has) begin
                e_ov = vbit(grant);
                e_d  = data[grant];
                e_g  = grant[1:0];
                e_r[grant[1:0]] = ready;
            end
            chk($sformatf("dut%0d valid", i), 32'(ov[i]), 32'(e_ov));
            chk($sformatf("dut%0d data", i), 32'(dout[i]), 32'(e_d));
            chk($sformatf("dut%0d grant_id", i), 32'(gid[i]), 32'(e_g));
            chk($sformatf("dut%0d req_ready", i), 32'(rdy[i]), 32'(e_r));

            xfer = e_ov && ready;
            if (reset || clr) begin
                owner[i] = -1;
                beats[i] = 0;
                ptr[i]   = 0;
            end else if (owner[i] < 0) begin
                if (has) begin
                    if (!xfer) begin
                        owner[i] = grant;
                        beats[i] = 0;
                    end else if (bl[i] == 1) begin
                        ptr[i] = (grant + 1) % NR;
                    end else begin
                        owner[i] = grant;
                        beats[i] = 1;
                    end
                end
            end else if (!vbit(owner[i])) begin
                owner[i] = -1;
                beats[i] = 0;
                ptr[i]   = (grant + 1) % NR;
            end else if (xfer) begin
                beats[i]++;
                if (beats[i] == bl[i]) begin
                    owner[i] = -1;
                    beats[i] = 0;
                    ptr[i]   = (grant + 1) % NR;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic c, input logic [NR-1:0] v, input logic rd);
        reset = r;
        clr   = c;
        valid = v;
        ready = rd;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            s_rdy[i]  = rdy[i];
            s_ov[i]   = ov[i];
            s_dout[i] = dout[i];
            s_gid[i]  = gid[i];
        end
        model_check_update();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          rst;
        logic [NR-1:0] valid;
        logic          ready;
        logic [1:0]    gid;
        logic          ov;
        logic [NR-1:0] rdy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [NR-1:0] v, input logic rd,
                                input logic [1:0] g, input logic o, input logic [NR-1:0] q);
        vec_t t;
        t.rst = r; t.valid = v; t.ready = rd; t.gid = g; t.ov = o; t.rdy = q;
        return t;
    endfunction

    vec_t vecs [15];
    int   exp_burst [7] = '{1, 1, 1, 3, 3, 3, 1};

    initial begin
        bl[0] = 1;
        bl[1] = 3;
        bl[2] = 4;
        model_reset();
        reset = 1'b1;
        clr   = 1'b0;
        valid = '0;
        ready = 1'b0;
        for (int k = 0; k < NR; k++) data[k] = 16'hA000 + 16'(k);

        // Rotation, then a stalled grant on req 2 with req 0 arriving late.
        vecs[0] = mk(1'b1, 4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000);
        for (int k = 1; k <= 8; k++) begin
            vecs[k] = mk(1'b0, 4'b1111, 1'b1, 2'((k - 1) % 4), 1'b1, 4'b0001 << ((k - 1) % 4));
        end
        vecs[9]  = mk(1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, 4'b0000);
        vecs[10] = mk(1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, 4'b0000);
        vecs[11] = mk(1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, 4'b0000);
        vecs[12] = mk(1'b0, 4'b0101, 1'b1, 2'd2, 1'b1, 4'b0100);
        vecs[13] = mk(1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0001);
        vecs[14] = mk(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000);

        @(posedge clk);
        #1;
        for (int r = 0; r < 15; r++) begin
            step(vecs[r].rst, 1'b0, vecs[r].valid, vecs[r].ready);
            chk($sformatf("vec%0d grant_id", r), 32'(s_gid[0]), 32'(vecs[r].gid));
            chk($sformatf("vec%0d valid", r), 32'(s_ov[0]), 32'(vecs[r].ov));
            chk($sformatf("vec%0d req_ready", r), 32'(s_rdy[0]), 32'(vecs[r].rdy));
            chk($sformatf("vec%0d data", r), 32'(s_dout[0]),
                vecs[r].ov ? 32'(16'hA000 + 16'(vecs[r].gid)) : 32'd0);
        end

        // Burst of 3 alternating between reqs 1 and 3.
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        for (int c = 0; c < 7; c++) begin
            step(1'b0, 1'b0, 4'b1010, 1'b1);
            chk($sformatf("burst%0d grant_id", c), 32'(s_gid[1]), 32'(exp_burst[c]));
        end

        // Drop mid-burst: req 0 leaves after 2 of 4 beats.
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        step(1'b0, 1'b0, 4'b0101, 1'b1);
        chk("drop beat1 grant_id", 32'(s_gid[2]), 32'd0);
        step(1'b0, 1'b0, 4'b0101, 1'b1);
        chk("drop beat2 valid", 32'(s_ov[2]), 32'd1);
        step(1'b0, 1'b0, 4'b0100, 1'b1);
        chk("drop idle valid", 32'(s_ov[2]), 32'd0);
        step(1'b0, 1'b0, 4'b0100, 1'b1);
        chk("drop next grant_id", 32'(s_gid[2]), 32'd2);
        chk("drop next valid", 32'(s_ov[2]), 32'd1);

        // Reset mid-burst at cnt=2 on the burst-3 instance.
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        step(1'b0, 1'b0, 4'b1010, 1'b1);
        step(1'b0, 1'b0, 4'b1010, 1'b1);
        step(1'b1, 1'b0, 4'b1111, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst dut%0d outputs", i),
                {s_ov[i], 9'd0, s_gid[i], s_rdy[i], s_dout[i]}, 32'd0);
        end
        step(1'b0, 1'b0, 4'b1111, 1'b1);
        chk("after rst grant_id", 32'(s_gid[1]), 32'd0);

        // Clear mid-burst: outputs not gated, next arbitration restarts at req 0.
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        step(1'b0, 1'b0, 4'b1010, 1'b1);
        step(1'b0, 1'b1, 4'b1010, 1'b1);
        chk("clear cycle valid", 32'(s_ov[1]), 32'd1);
        chk("clear cycle grant_id", 32'(s_gid[1]), 32'd1);
        step(1'b0, 1'b0, 4'b1011, 1'b1);
        chk("after clear grant_id", 32'(s_gid[1]), 32'd0);

        // An empty bypass FIFO with ready output passes its input straight through,
        // so the payload must be on the arbiter output in the request cycle itself.
        step(1'b0, 1'b0, 4'b0000, 1'b1);
        data[2] = 16'h5A5A;
        step(1'b0, 1'b0, 4'b0100, 1'b1);
        chk("zero latency valid", 32'(s_ov[0]), 32'd1);
        chk("zero latency data", 32'(s_dout[0]), 32'h5A5A);

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < NR; k++) data[k] = 16'($urandom);
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 39) == 0),
                 4'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64: width of each requester payload and of the output payload.
REQ-002 The block SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 2..16.
REQ-003 The block SHALL have parameter BURST_LEN, default 1: maximum consecutive transfers granted to one requester, legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port i__req_valid, input, NUM_REQ bits: per-requester valid, bit k belonging to requester k.
REQ-007 The block SHALL have port ia__req_data, input, array [0:NUM_REQ-1] of DATA_WIDTH bits: per-requester payload.
REQ-008 The block SHALL have port o__req_ready, output, NUM_REQ bits: per-requester accept strobe.
REQ-009 The block SHALL have port o__data_out_valid, output, 1 bit: output payload valid, intended to drive the data-in valid of a downstream bypass FIFO.
REQ-010 The block SHALL have port o__data_out, output, DATA_WIDTH bits: output payload.
REQ-011 The block SHALL have port i__data_out_ready, input, 1 bit: downstream accept.
REQ-012 The block SHALL have port o__grant_id, output, $clog2(NUM_REQ) bits: index of the current grant.
REQ-013 The block SHALL have port i__clear_all, input, 1 bit: synchronous clear of all arbitration state.

Function
REQ-014 The block SHALL keep these state elements: state (IDLE/BUSY), grant register g, round-robin pointer rr_ptr, and burst counter cnt (8 bits).
REQ-015 The block SHALL, in IDLE, combinationally select the first k with i__req_valid[k]=1, searching cyclically from rr_ptr upward with wrap from NUM_REQ-1 to 0; arbitration latency SHALL be zero cycles.
REQ-016 The block SHALL, in BUSY, use g as the grant and ignore all other requesters.
REQ-017 The block SHALL drive o__data_out_valid = i__req_valid[grant], o__data_out = ia__req_data[grant], and o__grant_id = grant when a grant exists; otherwise it SHALL drive all three to 0.
REQ-018 The block SHALL drive o__req_ready[grant] = i__data_out_ready and every other o__req_ready bit to 0; it SHALL never assert more than one o__req_ready bit.
REQ-019 A transfer SHALL be defined as o__data_out_valid=1 and i__data_out_ready=1 in the same cycle.
REQ-020 In IDLE, when a grant exists and no transfer occurs, the block SHALL go to BUSY with g = grant and cnt = 0, so that the grant is stable while output valid is stalled.
REQ-021 In IDLE, when a transfer occurs and BURST_LEN=1, the block SHALL stay in IDLE with rr_ptr = (grant+1) mod NUM_REQ.
REQ-022 In IDLE, when a transfer occurs and BURST_LEN>1, the block SHALL go to BUSY with g = grant and cnt = 1.
REQ-023 In BUSY, on a transfer with cnt+1 = BURST_LEN, the block SHALL go to IDLE with rr_ptr = (g+1) mod NUM_REQ and cnt = 0; otherwise cnt SHALL increment.
REQ-024 In BUSY, when i__req_valid[g]=0, the block SHALL go to IDLE with rr_ptr = (g+1) mod NUM_REQ and cnt = 0; in that cycle o__data_out_valid SHALL be 0.
REQ-025 The block SHALL leave all state unchanged in any cycle with no transfer, except the transitions in REQ-020 and REQ-024.
REQ-026 Requesters SHALL hold valid and data stable until accepted; the block SHALL NOT re-arbitrate a stalled grant.
REQ-027 Simultaneous valid on all requesters SHALL be served in strict rotation; no requester SHALL wait more than (NUM_REQ-1)*BURST_LEN transfers once valid.

Reset
REQ-028 While reset=1 at a rising edge, the block SHALL set state=IDLE, rr_ptr=0, g=0, cnt=0.
REQ-029 During a reset cycle, the block SHALL force o__data_out_valid=0, o__req_ready=0, o__data_out=0, and o__grant_id=0, regardless of its inputs.
REQ-030 i__clear_all=1 SHALL have the same state effect as reset at the next edge; it SHALL NOT gate outputs combinationally, and reset SHALL take priority over it.
REQ-031 Reset or clear asserted in BUSY mid-burst SHALL abandon the burst, with no transfer counted.

Verification
REQ-032 Rotation scenario: NUM_REQ=4, BURST_LEN=1, i__req_valid=4'b1111, ready=1 for 8 cycles -> o__grant_id sequence 0,1,2,3,0,1,2,3, one o__req_ready bit per cycle.
REQ-033 Stall scenario: req 2 only valid, ready=0 for 3 cycles, then req 0 also valid and ready=1 -> grant stays 2 during the stall, req 2 data is accepted first, then grant 0.
REQ-034 Burst scenario: BURST_LEN=3, reqs 1 and 3 valid, ready=1 -> grants 1,1,1,3,3,3,1.
REQ-035 Drop scenario: BURST_LEN=4, req 0 sends 2 beats then deasserts valid, req 2 valid -> one idle cycle, then grant 2; rr_ptr=1 after the drop.
REQ-036 Reset scenario: reset pulse mid-burst with cnt=2 -> next cycle rr_ptr=0, state IDLE, all outputs 0 during the reset cycle, and req 0 wins if valid.
REQ-037 Zero-latency scenario: the arbiter drives the data-in side of a bypass FIFO (DEPTH=3) whose output is ready -> the payload appears at the FIFO output in the same cycle the request is asserted.
